// File: rtl/io_ser_front_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_ser_front_pkg
// Description : Shared state encoding, default timeout and helpers for the
//               serial front end of the SRAM I/O path.
// Revision    : 1.0 - initial release
// ============================================================================
package io_ser_front_pkg;

    // Front-end controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SOUT  = 3'd5
    } state_t;

    // Default number of cycles to wait for a read response
    localparam int c_TMO_DEFAULT = 255;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_ser_shift.sv
`default_nettype none
// ============================================================================
// Module      : io_ser_shift
// Description : Parallel-load / serial-in / serial-out shift register, MSB
//               first. Used for address capture, write data and readback.
// Revision    : 1.0 - initial release
// ============================================================================
module io_ser_shift #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_din,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Parallel load wins over shift; shifting moves toward the MSB
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_sin};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/io_ser_front.sv
`default_nettype none
// ============================================================================
// Module      : io_ser_front
// Description : Serial frame front end. Receives opcode/address/data frames,
//               issues a request toward io_intf, waits for read data and
//               shifts it back out serially.
// Revision    : 1.0 - initial release
// ============================================================================
module io_ser_front
    import io_ser_front_pkg::*;
#(
    parameter int BITS   = 32,
    parameter int ADDR_W = 6,
    parameter int TMO    = c_TMO_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_en,
    input  logic              ser_in,
    output logic              ser_out,
    output logic              ser_busy,
    output logic              req_val,
    input  logic              req_rdy,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [BITS-1:0]   req_data,
    input  logic              rsp_val,
    input  logic [BITS-1:0]   rsp_data,
    output logic              done,
    output logic              err
);

    localparam int                 c_CNT_W     = $clog2(max_int(ADDR_W, BITS)) + 1;
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(BITS - 1);
    localparam logic [7:0]         c_TMO_LAST  = 8'(TMO - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_op;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_tmo;
    logic                 r_done;
    logic                 r_err;

    logic                 w_op_ld;
    logic                 w_addr_sh;
    logic                 w_data_sh;
    logic                 w_data_ld;
    logic                 w_sin;
    logic                 w_cnt_inc;
    logic                 w_cnt_clr;
    logic                 w_tmo_inc;
    logic                 w_tmo_clr;
    logic                 w_done_set;
    logic                 w_err_set;
    logic [ADDR_W-1:0]    w_addr_q;
    logic [BITS-1:0]      w_data_q;

    io_ser_shift #(.W(ADDR_W)) u_addr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (1'b0),
        .i_din   ({ADDR_W{1'b0}}),
        .i_shift (w_addr_sh),
        .i_sin   (ser_in),
        .o_q     (w_addr_q)
    );

    io_ser_shift #(.W(BITS)) u_data (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_data_ld),
        .i_din   (rsp_data),
        .i_shift (w_data_sh),
        .i_sin   (w_sin),
        .o_q     (w_data_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_next     = r_state;
        w_op_ld    = 1'b0;
        w_addr_sh  = 1'b0;
        w_data_sh  = 1'b0;
        w_data_ld  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_tmo_inc  = 1'b0;
        w_tmo_clr  = 1'b0;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        // Readback shifts zeros in behind the outgoing bits
        w_sin      = (r_state == ST_SOUT) ? 1'b0 : ser_in;
        case (r_state)
            ST_IDLE: begin
                if (ser_en) begin
                    w_op_ld   = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!ser_en) begin
                    w_err_set = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_addr_sh = 1'b1;
                    if (r_cnt == c_ADDR_LAST) begin
                        w_cnt_clr = 1'b1;
                        w_next    = r_op ? ST_DATA : ST_ISSUE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (!ser_en) begin
                    w_err_set = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_data_sh = 1'b1;
                    if (r_cnt == c_DATA_LAST) begin
                        w_cnt_clr = 1'b1;
                        w_next    = ST_ISSUE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (req_rdy) begin
                    if (r_op) begin
                        w_done_set = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_tmo_clr = 1'b1;
                        w_next    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rsp_val) begin
                    w_data_ld = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = ST_SOUT;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_err_set = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_SOUT: begin
                w_data_sh = 1'b1;
                if (r_cnt == c_DATA_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_done_set = 1'b1;
                    w_next     = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Opcode, bit/timeout counters, done pulse and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op   <= 1'b0;
            r_cnt  <= '0;
            r_tmo  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_op_ld) begin
                r_op <= ser_in;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + 8'd1;
            end
        end
    end

    assign ser_out  = (r_state == ST_SOUT) && w_data_q[BITS-1];
    assign ser_busy = (r_state != ST_IDLE);
    assign req_val  = (r_state == ST_ISSUE);
    assign req_wr   = r_op;
    assign req_addr = w_addr_q;
    assign req_data = w_data_q;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire
